bram_read_ctrl: RTL and testbench
=================================

Name: bram_read_ctrl

Overview:
- Read-side sequencer for the BRAM accessor. Accepts a burst request (base address, word count) and issues one BRAM read per cycle with a sequential address.
- Absorbs the fixed BRAM read latency.
- Streams the read words out on a valid/ready interface, with backpressure handled by a small credit-protected output FIFO.
- Pulses done_o once the last word has been accepted downstream.

Parameters:
- ADDR_WIDTH, 7, BRAM address width; also the width of the issued-word counter.
- DATA_WIDTH, 32, BRAM read data width.
- RD_LAT, 1, BRAM read latency in cycles, from bram_en_o/bram_addr_o to valid bram_rdata_i; legal values 1..3.
- FIFO_DEPTH, RD_LAT+2, output FIFO entries; must be >= RD_LAT+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  burst request; sampled only in IDLE.
- base_i  in  ADDR_WIDTH  first BRAM address of the burst.
- num_i  in  ADDR_WIDTH+1  number of words to read, 0..2^ADDR_WIDTH.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse at burst completion.
- bram_en_o  out  1  BRAM read enable.
- bram_addr_o  out  ADDR_WIDTH  BRAM read address.
- bram_rdata_i  in  DATA_WIDTH  BRAM read data, valid RD_LAT cycles after bram_en_o.
- data_o  out  DATA_WIDTH  stream data (FIFO head).
- valid_o  out  1  stream valid; equals FIFO not-empty.
- ready_i  in  1  downstream ready.

Behaviour:
- Reset values: busy_o=0, done_o=0, bram_en_o=0, bram_addr_o=0, valid_o=0, data_o=0. Reset also empties the FIFO and clears the in-flight pipeline.
- Reset mid-burst: the burst is abandoned; no done_o is generated.
- FSM IDLE:
  - start_i=1 latches base_i and num_i and clears issued count (iss) and popped count (pop).
  - num_i=0 -> DONE; otherwise -> ISSUE.
  - start_i outside IDLE is ignored, with no queuing.
- FSM ISSUE:
  - Read is issued this cycle when iss < num and credit is available. Credit = fifo_count + inflight < FIFO_DEPTH, where inflight = number of reads issued and not yet written into the FIFO.
  - On issue: bram_en_o=1, bram_addr_o = (base + iss) mod 2^ADDR_WIDTH, iss increments.
  - Address wraps from 2^ADDR_WIDTH-1 to 0 with no error.
  - bram_addr_o holds its last value when bram_en_o=0.
  - When the final read is issued -> DRAIN.
- Read pipeline: a RD_LAT-deep valid shift register follows bram_en_o. Its output pushes bram_rdata_i into the FIFO. The credit rule guarantees the FIFO is never written while full.
- FSM DRAIN: waits until pop == num -> DONE.
- FSM DONE: done_o=1 for exactly this one cycle, then -> IDLE. busy_o is still 1 in DONE.
- Stream handshake:
  - A word transfers when valid_o & ready_i, popping the FIFO and incrementing pop.
  - data_o/valid_o are stable while valid_o=1 and ready_i=0.
  - Same-cycle FIFO push and pop are allowed at any occupancy, including full and empty. Count is unchanged on simultaneous push and pop.
- Throughput:
  - With ready_i held high: one word per cycle.
  - First valid_o is RD_LAT+1 cycles after the start_i cycle. This includes 1 cycle of FIFO registration.
  - done_o occurs the cycle after the last transfer.
- Arithmetic: iss and pop are ADDR_WIDTH+1 bits so that num = 2^ADDR_WIDTH is representable.

Optional Feature:
- Macro BRAM_READ_CTRL_STALL_CNT_EN.
- When defined: adds output stall_cnt_o [15:0], which counts cycles where valid_o=1 and ready_i=0 during the current burst. It clears on burst start, saturates at 16'hFFFF, and holds its value after DONE until the next start.
- When undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package bram_acc_pkg holds:
  - FSM state encoding (IDLE, ISSUE, DRAIN, DONE, 2-bit)
  - default ADDR_WIDTH and DATA_WIDTH constants
  - RD_LAT legal-range constants
- One sub-module: bram_rd_fifo, a synchronous FIFO with parameters DEPTH and WIDTH, push/pop, full/empty/count, and first-word-fall-through head. The top holds the FSM, counters, credit logic and latency pipeline.

Test Plan:
- Basic burst, ready_i=1, base=5, num=4, RD_LAT=1 -> addrs 5,6,7,8 on consecutive cycles; data words D5..D8 in order; done_o one pulse 1 cycle after the last transfer.
- Wrap, ADDR_WIDTH=7, base=126, num=4 -> addrs 126,127,0,1.
- Backpressure, num=10, ready_i low for 8 cycles mid-burst -> bram_en_o stops once credit is exhausted; no word lost or duplicated; FIFO never overflows; the output sequence is exact.
- num=0 -> busy_o high for 1 cycle (DONE) with done_o=1; bram_en_o never asserts; valid_o stays 0.
- A second start_i during ISSUE (base=50) is ignored, and the first burst completes unchanged. rst_n asserted mid-burst then released -> all outputs reset, no done_o, and a following start works normally.
- Max burst num=128, RD_LAT=3, random ready_i -> 128 words in address order; with BRAM_READ_CTRL_STALL_CNT_EN defined, stall_cnt_o equals the bench-counted stall cycles.

Source files
------------

// File: rtl/bram_acc_pkg.sv
// Shared definitions for the BRAM accessor: FSM encoding, default widths and
// the legal range of BRAM read latency.
package bram_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int RD_LAT_MIN     = 1;
  localparam int RD_LAT_MAX     = 3;

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// Small synchronous FIFO with first-word-fall-through head; the head reads as
// zero while empty. Simultaneous push and pop are legal at any occupancy.
module bram_rd_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok, pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign pop_ok  = pop & ~empty;
  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/bram_read_ctrl.sv
// Burst read sequencer: issues sequential BRAM reads under FIFO credit and
// streams the words out. Optional stall counter: BRAM_READ_CTRL_STALL_CNT_EN.
module bram_read_ctrl
  import bram_acc_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = RD_LAT + 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH:0]   num_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  bram_en_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  input  logic [DATA_WIDTH-1:0] bram_rdata_i,
`ifdef BRAM_READ_CTRL_STALL_CNT_EN
  output logic [15:0]           stall_cnt_o,
`endif
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  if (!rd_lat_legal(RD_LAT) || (FIFO_DEPTH < RD_LAT + 1)) begin : g_bad_cfg
    $error("bram_read_ctrl: illegal RD_LAT / FIFO_DEPTH combination");
  end

  rd_state_e             state_reg, state_next;
  logic [ADDR_WIDTH-1:0] base_reg, addr_hold_reg, issue_addr;
  logic [ADDR_WIDTH:0]   num_reg, iss_reg, pop_reg, pop_next;
  logic [CW-1:0]         inflight_reg, fifo_count;
  logic [CW:0]           occupancy;
  logic [RD_LAT-1:0]     vld_reg;
  logic                  issue, credit, push, fire, fifo_full, fifo_empty, start_ok;

  assign start_ok   = (state_reg == IDLE) && start_i;
  assign issue_addr = base_reg + iss_reg[ADDR_WIDTH-1:0];
  // Reads still in the BRAM pipeline hold a FIFO slot, so the FIFO never overflows.
  assign occupancy  = {1'b0, fifo_count} + {1'b0, inflight_reg};
  assign credit     = !fifo_full && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign issue      = (state_reg == ISSUE) && (iss_reg < num_reg) && credit;
  assign push       = vld_reg[RD_LAT-1];
  assign valid_o    = ~fifo_empty;
  assign fire       = valid_o & ready_i;
  assign pop_next   = pop_reg + (ADDR_WIDTH+1)'(fire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_i) state_next = (num_i == '0) ? DONE : ISSUE;
      ISSUE:   if (issue && (iss_reg + CNT_ONE == num_reg)) state_next = DRAIN;
      // Looking at the post-transfer pop count lets done_o follow the last transfer directly.
      DRAIN:   if (pop_next == num_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_reg != IDLE);
    done_o      = (state_reg == DONE);
    bram_en_o   = issue;
    bram_addr_o = issue ? issue_addr : addr_hold_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_reg      <= '0;
      num_reg       <= '0;
      iss_reg       <= '0;
      pop_reg       <= '0;
      addr_hold_reg <= '0;
      inflight_reg  <= '0;
      vld_reg       <= '0;
    end else begin
      if (start_ok) begin
        base_reg <= base_i;
        num_reg  <= num_i;
        iss_reg  <= '0;
        pop_reg  <= '0;
      end else begin
        if (issue) iss_reg <= iss_reg + CNT_ONE;
        pop_reg <= pop_next;
      end
      if (issue) addr_hold_reg <= issue_addr;
      case ({issue, push})
        2'b10:   inflight_reg <= inflight_reg + CW'(1);
        2'b01:   inflight_reg <= inflight_reg - CW'(1);
        default: inflight_reg <= inflight_reg;
      endcase
      vld_reg[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) vld_reg[i] <= vld_reg[i-1];
    end
  end

  bram_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (bram_rdata_i),
    .pop   (fire),
    .rdata (data_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef BRAM_READ_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                 stall_cnt_reg <= '0;
    else if (start_ok)                                          stall_cnt_reg <= '0;
    else if (valid_o && !ready_i && (stall_cnt_reg != 16'hFFFF)) stall_cnt_reg <= stall_cnt_reg + 16'd1;
  end

  assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_bram_read_ctrl.sv
// Directed bench for bram_read_ctrl: one instance with RD_LAT=1, one with RD_LAT=3,
// each fed by a behavioural BRAM returning 0xD00D0000 | address.
`timescale 1ns/1ps
module tb_bram_read_ctrl;
  localparam int AW = 7;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start [2];
  logic [AW-1:0] base  [2];
  logic [AW:0]   num   [2];
  logic          ready [2];
  logic          busy  [2];
  logic          done  [2];
  logic          en    [2];
  logic          valid [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] data  [2];
  logic [DW-1:0] r1, r3_0, r3_1, r3_2;
  logic [15:0]   stall0, stall1;

  function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
    return 32'hD00D_0000 | {25'd0, a};
  endfunction

  always @(posedge clk) begin
    r1   <= dat(addr[0]);
    r3_0 <= dat(addr[1]);
    r3_1 <= r3_0;
    r3_2 <= r3_1;
  end

  bram_read_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .base_i(base[0]), .num_i(num[0]),
    .busy_o(busy[0]), .done_o(done[0]), .bram_en_o(en[0]), .bram_addr_o(addr[0]),
    .bram_rdata_i(r1),
`ifdef BRAM_READ_CTRL_STALL_CNT_EN
    .stall_cnt_o(stall0),
`endif
    .data_o(data[0]), .valid_o(valid[0]), .ready_i(ready[0])
  );

  bram_read_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .base_i(base[1]), .num_i(num[1]),
    .busy_o(busy[1]), .done_o(done[1]), .bram_en_o(en[1]), .bram_addr_o(addr[1]),
    .bram_rdata_i(r3_2),
`ifdef BRAM_READ_CTRL_STALL_CNT_EN
    .stall_cnt_o(stall1),
`endif
    .data_o(data[1]), .valid_o(valid[1]), .ready_i(ready[1])
  );

  // Per-instance observation, sampled mid-cycle.
  int n_addr [2], n_xfer [2], done_cnt [2], done_cyc [2], last_xfer [2];
  int first_valid [2], start_cyc [2], busy_cyc [2], stalls [2], max_out [2];
  int en_first [2], en_last [2];
  logic [AW-1:0] addr_log [2][256];
  logic [DW-1:0] data_log [2][256];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (start[d] && !busy[d]) start_cyc[d] = cyc;
      if (busy[d]) busy_cyc[d]++;
      if (en[d]) begin
        if (n_addr[d] == 0) en_first[d] = cyc;
        en_last[d] = cyc;
        if (n_addr[d] < 256) addr_log[d][n_addr[d]] = addr[d];
        n_addr[d]++;
        if (n_addr[d] - n_xfer[d] > max_out[d]) max_out[d] = n_addr[d] - n_xfer[d];
      end
      if (valid[d] && first_valid[d] < 0) first_valid[d] = cyc;
      if (valid[d] && ready[d]) begin
        if (n_xfer[d] < 256) data_log[d][n_xfer[d]] = data[d];
        n_xfer[d]++;
        last_xfer[d] = cyc;
      end
      if (valid[d] && !ready[d]) stalls[d]++;
      if (done[d]) begin
        done_cnt[d]++;
        done_cyc[d] = cyc;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr(input int d);
    n_addr[d] = 0; n_xfer[d] = 0; done_cnt[d] = 0; done_cyc[d] = -1; last_xfer[d] = -1;
    first_valid[d] = -1; start_cyc[d] = -1; busy_cyc[d] = 0; stalls[d] = 0; max_out[d] = 0;
    en_first[d] = -1; en_last[d] = -1;
  endtask

  task automatic start_burst(input int d, input int b, input int n);
    base[d]  = AW'(b);
    num[d]   = (AW+1)'(n);
    start[d] = 1'b1;
    step(1);
    start[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int limit);
    int k = 0;
    while (done_cnt[d] == 0 && k < limit) begin
      step(1);
      k++;
    end
    if (done_cnt[d] == 0) chk("done_timeout", done_cnt[d], 1);
    step(1);
  endtask

  task automatic check_burst(input int d, input string tag, input int b, input int n,
                             input int lat, input bit contiguous);
    logic [AW-1:0] a;
    $display("burst %s: base=%0d num=%0d issued=%0d words=%0d dones=%0d stalls=%0d",
             tag, b, n, n_addr[d], n_xfer[d], done_cnt[d], stalls[d]);
    chk({tag, "_issued"}, n_addr[d], n);
    chk({tag, "_words"}, n_xfer[d], n);
    for (int i = 0; i < n && i < 256; i++) begin
      a = AW'(b + i);
      chk({tag, "_addr"}, {25'd0, addr_log[d][i]}, {25'd0, a});
      chk({tag, "_data"}, data_log[d][i], dat(a));
    end
    chk({tag, "_done_pulses"}, done_cnt[d], 1);
    // done_o in the cycle right after the last transfer
    chk({tag, "_done_time"}, done_cyc[d], last_xfer[d] + 1);
    // valid_o rises RD_LAT+1 edges after the edge that samples start_i
    chk({tag, "_first_valid"}, first_valid[d] - (start_cyc[d] + 1), lat + 1);
    if (contiguous) chk({tag, "_issue_span"}, en_last[d] - en_first[d], n - 1);
    chk({tag, "_idle_after"}, {31'd0, busy[d]}, 0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; base[d] = '0; num[d] = '0; ready[d] = 1'b1;
      clr(d);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy",  {31'd0, busy[0]}, 0);
    chk("rst_done",  {31'd0, done[0]}, 0);
    chk("rst_en",    {31'd0, en[0]}, 0);
    chk("rst_addr",  {25'd0, addr[0]}, 0);
    chk("rst_valid", {31'd0, valid[0]}, 0);
    chk("rst_data",  data[0], 0);
    step(2);
    rst_n = 1'b1;
    step(2);

    clr(0); start_burst(0, 5, 4); wait_done(0, 100);
    check_burst(0, "basic", 5, 4, 1, 1'b1);

    clr(0); start_burst(0, 126, 4); wait_done(0, 100);
    check_burst(0, "wrap", 126, 4, 1, 1'b1);

    // Backpressure: ready low for 8 cycles while the FIFO is filling
    clr(0); start_burst(0, 40, 10);
    step(3); ready[0] = 1'b0;
    step(8); ready[0] = 1'b1;
    wait_done(0, 200);
    check_burst(0, "backpressure", 40, 10, 1, 1'b0);
    chk("bp_max_outstanding", max_out[0], 3);
    chk("bp_stall_cycles", stalls[0], 8);

    clr(0); start_burst(0, 7, 0); step(3);
    $display("burst num0: busy_cycles=%0d dones=%0d issued=%0d", busy_cyc[0], done_cnt[0], n_addr[0]);
    chk("num0_busy_cycles", busy_cyc[0], 1);
    chk("num0_done_pulses", done_cnt[0], 1);
    chk("num0_issued", n_addr[0], 0);
    chk("num0_no_valid", first_valid[0], -1);

    // A second start during ISSUE must be ignored
    clr(0); start_burst(0, 10, 6);
    start_burst(0, 50, 3);
    wait_done(0, 100);
    check_burst(0, "ignore_start", 10, 6, 1, 1'b1);

    // Reset mid-burst
    clr(0); start_burst(0, 20, 8); step(3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy",  {31'd0, busy[0]}, 0);
    chk("mid_rst_done",  {31'd0, done[0]}, 0);
    chk("mid_rst_en",    {31'd0, en[0]}, 0);
    chk("mid_rst_addr",  {25'd0, addr[0]}, 0);
    chk("mid_rst_valid", {31'd0, valid[0]}, 0);
    chk("mid_rst_data",  data[0], 0);
    step(2);
    rst_n = 1'b1;
    step(5);
    $display("reset mid-burst: dones=%0d", done_cnt[0]);
    chk("mid_rst_no_done", done_cnt[0], 0);
    clr(0); start_burst(0, 30, 2); wait_done(0, 100);
    check_burst(0, "after_reset", 30, 2, 1, 1'b1);

    // Max burst on the RD_LAT=3 instance with random ready
    clr(1); start_burst(1, 0, 128);
    for (int k = 0; k < 3000 && done_cnt[1] == 0; k++) begin
      ready[1] = 1'($urandom_range(0, 1));
      step(1);
    end
    ready[1] = 1'b1;
    if (done_cnt[1] == 0) chk("max_done_timeout", done_cnt[1], 1);
    step(2);
    check_burst(1, "max_burst", 0, 128, 3, 1'b0);
`ifdef BRAM_READ_CTRL_STALL_CNT_EN
    chk("max_stall_cnt", {16'd0, stall1}, stalls[1]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
